// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass and an
// integrated single-bit busy scoreboard for the issue stage.

module regfile_mp_rport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NWRITE = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic [ADDR_W-1:0]              raddr,
    input  logic [DATA_W-1:0]              stored,
    input  logic                           busy_bit,
    input  logic [NWRITE-1:0]              wr_ok,
    input  logic [NWRITE-1:0][ADDR_W-1:0]  waddr,
    input  logic [NWRITE-1:0][DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]              rdata,
    output logic                           rbusy
);
    always_comb begin
        rdata = stored;
        rbusy = busy_bit;
        // Ascending scan so the highest-index matching writer wins.
        if (BYPASS) begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wr_ok[j] && (waddr[j] == raddr)) begin
                    rdata = wdata[j];
                    rbusy = 1'b0;
                end
            end
        end
        if (raddr == '0) begin
            rdata = '0;
            rbusy = 1'b0;
        end
    end
endmodule

module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREAD*ADDR_W-1:0]  raddr,
    output logic [NREAD*DATA_W-1:0]  rdata,
    output logic [NREAD-1:0]         rbusy,
    input  logic [NWRITE-1:0]        we,
    input  logic [NWRITE*ADDR_W-1:0] waddr,
    input  logic [NWRITE*DATA_W-1:0] wdata,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [NWRITE-1:0][ADDR_W-1:0] wa;
    logic [NWRITE-1:0][DATA_W-1:0] wd;
    logic [NREAD-1:0][ADDR_W-1:0]  ra;
    logic [NREAD-1:0][DATA_W-1:0]  rd;
    logic [NWRITE-1:0]             wr_ok;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy, busy_nxt;
    logic [ADDR_W:0]   cnt_nxt;

    assign wa    = waddr;
    assign wd    = wdata;
    assign ra    = raddr;
    assign rdata = rd;

    // Writes to r0 are dropped here so neither storage, bypass nor busy sees them.
    always_comb begin
        for (int j = 0; j < NWRITE; j++)
            wr_ok[j] = we[j] && (wa[j] != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            for (int j = 0; j < NWRITE; j++)
                if (wr_ok[j])
                    mem[wa[j]] <= wd[j];
        end
    end

    // Apply lowest priority first so later assignments override: clear < set < flush.
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NWRITE; j++)
            if (wr_ok[j])
                busy_nxt[wa[j]] = 1'b0;
        if (iss_valid && (iss_addr != '0))
            busy_nxt[iss_addr] = 1'b1;
        if (flush)
            busy_nxt = '0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rport
        regfile_mp_rport #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W),
            .NWRITE(NWRITE),
            .BYPASS(BYPASS)
        ) u_rport (
            .raddr   (ra[k]),
            .stored  (mem[ra[k]]),
            .busy_bit(busy[ra[k]]),
            .wr_ok   (wr_ok),
            .waddr   (wa),
            .wdata   (wd),
            .rdata   (rd[k]),
            .rbusy   (rbusy[k])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypass and non-bypass instances share stimulus;
// a directed vector table plus a few multi-cycle scoreboard sequences.

module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  raddr;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        flush;

    logic [63:0] rdata_b, rdata_n;
    logic [1:0]  rbusy_b, rbusy_n;
    logic [5:0]  cnt_b, cnt_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .NWRITE(2), .BYPASS(1'b1)) dut_b (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .we(we), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
        .iss_addr(iss_addr), .flush(flush), .busy_cnt(cnt_b));

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .NWRITE(2), .BYPASS(1'b0)) dut_n (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .we(we), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
        .iss_addr(iss_addr), .flush(flush), .busy_cnt(cnt_n));

    typedef struct {
        logic        rs;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iv;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        chk;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_rb;
        logic [31:0] n_rd0;
        logic [31:0] n_rd1;
        logic [1:0]  n_rb;
        logic [5:0]  cnt;
    } vec_t;

    vec_t vt [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; we = 2'b00; waddr = '0; wdata = '0;
        iss_valid = 1'b0; iss_addr = '0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string name, input logic [5:0] exp);
        chk({name, " cnt_b"}, {26'd0, cnt_b}, {26'd0, exp});
        chk({name, " cnt_n"}, {26'd0, cnt_n}, {26'd0, exp});
    endtask

    initial begin
        //          rs    we     wa0   wd0            wa1    wd1        iv    ia    fl    ra0    ra1   chk   e_rd0          e_rd1          e_rb   n_rd0          n_rd1          n_rb   cnt
        vt[0]  = '{1'b1, 2'b11, 5'd3, 32'h55,        5'd3,  32'h66,   1'b0, 5'd0, 1'b0, 5'd3,  5'd0, 1'b0, 32'h0,         32'h0,         2'b00, 32'h0,         32'h0,         2'b00, 6'd0};
        vt[1]  = '{1'b0, 2'b00, 5'd0, 32'h0,         5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd3,  5'd0, 1'b1, 32'h0,         32'h0,         2'b00, 32'h0,         32'h0,         2'b00, 6'd0};
        vt[2]  = '{1'b0, 2'b01, 5'd5, 32'hDEADBEEF,  5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd5,  5'd3, 1'b1, 32'hDEADBEEF,  32'h0,         2'b00, 32'h0,         32'h0,         2'b00, 6'd0};
        vt[3]  = '{1'b0, 2'b00, 5'd0, 32'h0,         5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd5,  5'd3, 1'b1, 32'hDEADBEEF,  32'h0,         2'b00, 32'hDEADBEEF,  32'h0,         2'b00, 6'd0};
        vt[4]  = '{1'b0, 2'b11, 5'd7, 32'h1111,      5'd7,  32'h2222, 1'b0, 5'd0, 1'b0, 5'd7,  5'd5, 1'b1, 32'h2222,      32'hDEADBEEF,  2'b00, 32'h0,         32'hDEADBEEF,  2'b00, 6'd0};
        vt[5]  = '{1'b0, 2'b01, 5'd0, 32'h9999,      5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd0,  5'd7, 1'b1, 32'h0,         32'h2222,      2'b00, 32'h0,         32'h2222,      2'b00, 6'd0};
        vt[6]  = '{1'b0, 2'b00, 5'd0, 32'h0,         5'd0,  32'h0,    1'b1, 5'd4, 1'b0, 5'd4,  5'd0, 1'b1, 32'h0,         32'h0,         2'b00, 32'h0,         32'h0,         2'b00, 6'd0};
        vt[7]  = '{1'b0, 2'b00, 5'd0, 32'h0,         5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd4,  5'd0, 1'b1, 32'h0,         32'h0,         2'b01, 32'h0,         32'h0,         2'b01, 6'd1};
        vt[8]  = '{1'b0, 2'b01, 5'd4, 32'hA5,        5'd0,  32'h0,    1'b1, 5'd4, 1'b0, 5'd4,  5'd0, 1'b1, 32'hA5,        32'h0,         2'b00, 32'h0,         32'h0,         2'b01, 6'd1};
        vt[9]  = '{1'b0, 2'b00, 5'd0, 32'h0,         5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd4,  5'd4, 1'b1, 32'hA5,        32'hA5,        2'b11, 32'hA5,        32'hA5,        2'b11, 6'd1};
        vt[10] = '{1'b0, 2'b01, 5'd4, 32'h5A,        5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd4,  5'd0, 1'b1, 32'h5A,        32'h0,         2'b00, 32'hA5,        32'h0,         2'b01, 6'd1};
        vt[11] = '{1'b0, 2'b00, 5'd0, 32'h0,         5'd0,  32'h0,    1'b1, 5'd1, 1'b0, 5'd4,  5'd1, 1'b1, 32'h5A,        32'h0,         2'b00, 32'h5A,        32'h0,         2'b00, 6'd0};
        vt[12] = '{1'b0, 2'b00, 5'd0, 32'h0,         5'd0,  32'h0,    1'b1, 5'd2, 1'b0, 5'd1,  5'd2, 1'b1, 32'h0,         32'h0,         2'b01, 32'h0,         32'h0,         2'b01, 6'd1};
        vt[13] = '{1'b0, 2'b00, 5'd0, 32'h0,         5'd0,  32'h0,    1'b1, 5'd3, 1'b0, 5'd2,  5'd3, 1'b1, 32'h0,         32'h0,         2'b01, 32'h0,         32'h0,         2'b01, 6'd2};
        vt[14] = '{1'b0, 2'b10, 5'd0, 32'h0,         5'd10, 32'hCAFE, 1'b1, 5'd9, 1'b1, 5'd3,  5'd9, 1'b1, 32'h0,         32'h0,         2'b01, 32'h0,         32'h0,         2'b01, 6'd3};
        vt[15] = '{1'b0, 2'b00, 5'd0, 32'h0,         5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd9,  5'd10,1'b1, 32'h0,         32'hCAFE,      2'b00, 32'h0,         32'hCAFE,      2'b00, 6'd0};
        vt[16] = '{1'b0, 2'b00, 5'd0, 32'h0,         5'd0,  32'h0,    1'b1, 5'd6, 1'b0, 5'd6,  5'd5, 1'b1, 32'h0,         32'hDEADBEEF,  2'b00, 32'h0,         32'hDEADBEEF,  2'b00, 6'd0};
        vt[17] = '{1'b1, 2'b01, 5'd6, 32'h77,        5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd5,  5'd6, 1'b1, 32'hDEADBEEF,  32'h77,        2'b00, 32'hDEADBEEF,  32'h0,         2'b10, 6'd1};
        vt[18] = '{1'b0, 2'b00, 5'd0, 32'h0,         5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 5'd6,  5'd5, 1'b1, 32'h0,         32'h0,         2'b00, 32'h0,         32'h0,         2'b00, 6'd0};

        idle();
        raddr = '0;
        #1;
        for (int i = 0; i < 19; i++) begin
            reset     = vt[i].rs;
            we        = vt[i].we;
            waddr     = {vt[i].wa1, vt[i].wa0};
            wdata     = {vt[i].wd1, vt[i].wd0};
            iss_valid = vt[i].iv;
            iss_addr  = vt[i].ia;
            flush     = vt[i].fl;
            raddr     = {vt[i].ra1, vt[i].ra0};
            @(negedge clk);
            if (vt[i].chk) begin
                chk($sformatf("row%0d b.rd0", i), rdata_b[31:0],  vt[i].e_rd0);
                chk($sformatf("row%0d b.rd1", i), rdata_b[63:32], vt[i].e_rd1);
                chk($sformatf("row%0d b.rb", i),  {30'd0, rbusy_b}, {30'd0, vt[i].e_rb});
                chk($sformatf("row%0d n.rd0", i), rdata_n[31:0],  vt[i].n_rd0);
                chk($sformatf("row%0d n.rd1", i), rdata_n[63:32], vt[i].n_rd1);
                chk($sformatf("row%0d n.rb", i),  {30'd0, rbusy_n}, {30'd0, vt[i].n_rb});
                chk_cnt($sformatf("row%0d", i), vt[i].cnt);
            end
            tick();
        end

        // Fill the scoreboard completely; r0 can never be counted.
        idle();
        for (int a = 1; a < 32; a++) begin
            iss_valid = 1'b1;
            iss_addr  = 5'(a);
            tick();
        end
        idle();
        raddr = {5'd1, 5'd31};
        @(negedge clk);
        chk_cnt("fill", 6'd31);
        chk("fill rbusy_b", {30'd0, rbusy_b}, 32'd3);
        chk("fill rbusy_n", {30'd0, rbusy_n}, 32'd3);

        // Write-back r31 while issuing to r0 (which must not set anything).
        tick();
        we = 2'b01; waddr = {5'd0, 5'd31}; wdata = {32'h0, 32'h1};
        iss_valid = 1'b1; iss_addr = 5'd0;
        tick();
        idle();
        @(negedge clk);
        chk_cnt("wb r31", 6'd30);
        chk("wb r31 rbusy_b", {30'd0, rbusy_b}, 32'd2);
        chk("wb r31 rdata_b", rdata_b[31:0], 32'h1);

        // Re-issue to an already-busy register, then a single write-back clears it.
        tick();
        iss_valid = 1'b1; iss_addr = 5'd5;
        tick();
        idle();
        @(negedge clk);
        chk_cnt("reissue r5", 6'd30);
        tick();
        we = 2'b10; waddr = {5'd5, 5'd0}; wdata = {32'h5, 32'h0};
        tick();
        idle();
        @(negedge clk);
        chk_cnt("wb r5", 6'd29);

        tick();
        flush = 1'b1;
        tick();
        idle();
        @(negedge clk);
        chk_cnt("flush all", 6'd0);
        chk("flush rbusy_b", {30'd0, rbusy_b}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file. Successor to the 2R/1W register file.
- Configurable width, depth, read-port count and write-port count.
- Optional write-to-read bypass, synchronous clear, and an integrated busy scoreboard for the issue stage.
- Sits between decode/issue, which reads operands and marks destinations busy, and write-back, which writes results and clears busy.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W entries
NREAD, 2, number of read ports (1..4)
NWRITE, 2, number of write ports (1..2)
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads return stored value only

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; sampled on rising edge of clk
raddr  in  NREAD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rdata  out  NREAD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W], combinational
rbusy  out  NREAD  per-read-port busy flag of addressed register, combinational
we  in  NWRITE  per-port write enable, high active
waddr  in  NWRITE*ADDR_W  write addresses
wdata  in  NWRITE*DATA_W  write data
iss_valid  in  1  issue marks iss_addr busy
iss_addr  in  ADDR_W  destination register of issuing instruction
flush  in  1  clears all busy bits (pipeline flush); data untouched
busy_cnt  out  ADDR_W+1  registered count of busy registers

Behaviour:
- Storage: 2**ADDR_W x DATA_W array plus busy vector of 2**ADDR_W bits.
- Reset: while reset=1 at a clk edge, all data entries <= 0, all busy <= 0, busy_cnt <= 0. Reset overrides writes, issue and flush in that cycle. Reset mid-operation discards all in-flight state. Outputs after reset: rdata = 0, rbusy = 0 for every address.
- Register 0: writes are ignored. Reads of address 0 return 0 and rbusy = 0 regardless of bypass. Issue to address 0 does not set busy.
- Write: on rising edge, for each port j with we[j]=1 and waddr[j]!=0, the entry <= wdata[j]. Data is visible through the array on the following cycle.
- Write conflict: if both ports write the same address in one cycle, the higher-index port wins.
- Read, BYPASS=1: if any port j has we[j]=1 and waddr[j]==raddr[k]!=0 in the same cycle, rdata[k] = wdata of the highest such j. Otherwise rdata[k] = the stored value. Zero-cycle latency.
- Read, BYPASS=0: rdata[k] = the stored value only; new data appears the cycle after the write.
- Busy clear: each write with we[j]=1 and waddr[j]!=0 clears busy[waddr[j]] at the edge.
- Busy set: iss_valid=1 with iss_addr!=0 sets busy[iss_addr] at the edge.
- Set and clear same register, same cycle: set wins (the newer producer is outstanding).
- Re-issue: issuing to an already-busy register is legal; busy stays 1. A single write-back then clears it (single-bit scoreboard; issue logic must not allow two outstanding writers to one register).
- Flush: flush=1 clears every busy bit at the edge. Flush also overrides iss_valid in the same cycle. Writes in a flush cycle still update data.
- Priority, highest first: reset > flush > issue-set > write-clear.
- rbusy[k] = busy[raddr[k]], combinational from the registered vector. It does not reflect same-cycle issue. When BYPASS=1 and a same-cycle write targets raddr[k], rbusy[k] = 0 (the data is being supplied).
- busy_cnt: registered population count of the next-state busy vector. Equals the number of busy bits visible in the same cycle as those bits. Range 0..2**ADDR_W-1 (r0 never counted).
- Out-of-range port counts are illegal; no runtime checking.

Test Plan:
- Reset then read: assert reset 1 cycle with we=2'b11, waddr0=3, wdata0=0x55 -> after release, read r3 = 0x00000000, rbusy=0, busy_cnt=0.
- Write/read and bypass: write r5=0xDEADBEEF on port0 while raddr0=5 -> rdata0=0xDEADBEEF same cycle (BYPASS=1) and 0 same cycle with BYPASS=0; next cycle both configurations return 0xDEADBEEF.
- Write conflict and r0: port0 r7=0x1111, port1 r7=0x2222, port0 r0=0x9999 in one cycle -> r7=0x2222, r0 reads 0.
- Scoreboard: issue r4 -> next cycle rbusy=1, busy_cnt=1. Write r4=0xA5 and issue r4 in the same cycle -> r4=0xA5, busy stays 1, busy_cnt=1. Write r4 alone -> busy 0, busy_cnt=0.
- Flush: issue r1, r2, r3 on consecutive cycles (busy_cnt 1,2,3), then flush with iss_valid=1 for r9 -> next cycle busy_cnt=0 and r9 is not busy.
- Reset mid-operation: with r6 busy and a write to r6=0x77 pending, assert reset -> all busy 0, r6 reads 0, busy_cnt=0.
